flit_fifo: RTL
==============

FLIT_FIFO -- requirements
Module: flit_fifo

Interface
REQ-001 Parameter DATA_SIZE, default 4: payload bits per flit.
REQ-002 Parameter ADDR_SIZE, default 1: destination address bits per flit.
REQ-003 Parameter DEPTH_LOG, default 2: buffer depth is 2**DEPTH_LOG flits.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port a_rst  input  1  reset, asynchronous, active-low.
REQ-006 Port wr_req  input  1  write strobe from the upstream receiver.
REQ-007 Port data_i  input  DATA_SIZE+ADDR_SIZE+1  flit to store.
REQ-008 Port is_full  output  1  high when the buffer holds 2**DEPTH_LOG flits.
REQ-009 Port rd_req  input  1  pop strobe from the downstream consumer.
REQ-010 Port data_o  output  DATA_SIZE+ADDR_SIZE+1  head flit, first-word-fall-through.
REQ-011 Port is_empty  output  1  high when the buffer holds 0 flits.
REQ-012 Port count  output  DEPTH_LOG+1  current occupancy.
REQ-013 Port ovf  output  1  sticky flag: write attempted while full.
REQ-014 Port udf  output  1  sticky flag: read attempted while empty.

Function
REQ-015 Write accepted on a rising edge iff wr_req=1 and is_full=0; flit stored at write pointer, pointer increments modulo depth.
REQ-016 Read accepted on a rising edge iff rd_req=1 and is_empty=0; read pointer increments modulo depth.
REQ-017 data_o shall equal the oldest stored flit whenever is_empty=0, with zero-cycle latency from the write that made it visible plus one edge; undefined content not allowed: data_o=0 when empty.
REQ-018 is_full, is_empty, count shall be derived from registered state only; no combinational path from wr_req/rd_req.
REQ-019 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-020 Full with wr_req=1 and rd_req=1: read accepted, write rejected, ovf set, count decrements by 1.
REQ-021 Empty with wr_req=1 and rd_req=1: write accepted, read rejected, udf set, count becomes 1.
REQ-022 Pointers carry one extra wrap bit; full = pointers equal except MSB, empty = pointers fully equal.
REQ-023 ovf and udf clear only on reset.
REQ-024 Flits emerge in exact write order; no flit lost or duplicated across pointer wrap.

Reset
REQ-025 a_rst=0 shall immediately, without clk, force pointers=0, count=0, is_empty=1, is_full=0, data_o=0, ovf=0, udf=0.
REQ-026 Reset mid-operation discards all stored flits; first write after release reappears at data_o one edge later.
REQ-027 No write or read is accepted on an edge where a_rst=0.

Structure
REQ-028 Flit width expression (DATA_SIZE+ADDR_SIZE+1) shall be a shared constant in the NoC common package/include, reused by receiver and flit_fifo.
REQ-029 Storage shall be a sub-module fifo_mem (register array, one synchronous write port, one asynchronous read port); pointer/flag logic stays in flit_fifo.

Verification
REQ-030 Reset then idle -> is_empty=1, is_full=0, count=0, data_o=0, ovf=udf=0.
REQ-031 DEPTH_LOG=2: write 0x11,0x22,0x33,0x44 on 4 edges -> is_full=1, count=4, data_o=0x11; 5th write 0x55 -> ovf=1, count stays 4.
REQ-032 From full, 4 pops -> data_o sequence 0x11,0x22,0x33,0x44 then is_empty=1, data_o=0; extra pop -> udf=1.
REQ-033 Continuous simultaneous write/read for 10 edges at count=2 -> count stays 2, output order equals input order across two pointer wraps.
REQ-034 Full with wr_req=rd_req=1 -> count=3, ovf=1; empty with wr_req=rd_req=1 -> count=1, udf=1.
REQ-035 a_rst pulsed low between clock edges at count=3 -> outputs reset immediately; next write 0x2A -> data_o=0x2A, count=1.

Source files
------------

// File: rtl/flit_fifo_pkg.sv
// ============================================================================
// Module  : flit_fifo_pkg
// Brief   : Shared NoC constants and the flit-width helper used by the
//           receiver, the flit FIFO and its storage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package flit_fifo_pkg;

  localparam int DATA_SIZE_DEF = 4;
  localparam int ADDR_SIZE_DEF = 1;
  localparam int DEPTH_LOG_DEF = 2;

  // One flit is payload + destination address + one framing bit.
  function automatic int flit_width(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

  localparam int FLIT_W_DEF = flit_width(DATA_SIZE_DEF, ADDR_SIZE_DEF);

endpackage

`default_nettype wire

// File: rtl/flit_fifo_if.sv
// ============================================================================
// Module  : flit_fifo_if
// Brief   : Push/pop handshake and status bundle of the flit FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface flit_fifo_if #(
  parameter int FLIT_W    = flit_fifo_pkg::FLIT_W_DEF,
  parameter int DEPTH_LOG = flit_fifo_pkg::DEPTH_LOG_DEF
);

  logic                wr_req;
  logic [FLIT_W-1:0]   data_i;
  logic                is_full;
  logic                rd_req;
  logic [FLIT_W-1:0]   data_o;
  logic                is_empty;
  logic [DEPTH_LOG:0]  count;
  logic                ovf;
  logic                udf;

  modport master (
    output wr_req, data_i, rd_req,
    input  is_full, data_o, is_empty, count, ovf, udf
  );

  modport slave (
    input  wr_req, data_i, rd_req,
    output is_full, data_o, is_empty, count, ovf, udf
  );

endinterface

`default_nettype wire

// File: rtl/flit_fifo_mem.sv
// ============================================================================
// Module  : fifo_mem
// Brief   : Register-array storage, one synchronous write port and one
//           asynchronous read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
  parameter int WIDTH  = flit_fifo_pkg::FLIT_W_DEF,
  parameter int ADDR_W = flit_fifo_pkg::DEPTH_LOG_DEF
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [WIDTH-1:0]  wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [WIDTH-1:0]  rdata
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [c_DEPTH];

  // Contents need no reset: the read side masks data while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/flit_fifo.sv
// ============================================================================
// Module  : flit_fifo
// Brief   : First-word-fall-through flit buffer with wrap-bit pointers and
//           sticky overflow/underflow flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_fifo
  import flit_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
  input  wire logic   clk,
  input  wire logic   a_rst,
  flit_fifo_if.slave  bus
);

  localparam int c_FLIT_W = flit_width(DATA_SIZE, ADDR_SIZE);

  logic [DEPTH_LOG:0]    r_wr_ptr;
  logic [DEPTH_LOG:0]    r_rd_ptr;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [c_FLIT_W-1:0]   w_rdata;

  // Status comes from the registered pointers only, so it never depends
  // combinationally on the request strobes.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG] != r_rd_ptr[DEPTH_LOG]) &&
                   (r_wr_ptr[DEPTH_LOG-1:0] == r_rd_ptr[DEPTH_LOG-1:0]);

  assign w_wr_en = bus.wr_req & ~w_full;
  assign w_rd_en = bus.rd_req & ~w_empty;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (bus.wr_req && w_full) begin
        r_ovf <= 1'b1;
      end
      if (bus.rd_req && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .WIDTH  (c_FLIT_W),
    .ADDR_W (DEPTH_LOG)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_en & a_rst),
    .waddr (r_wr_ptr[DEPTH_LOG-1:0]),
    .wdata (bus.data_i),
    .raddr (r_rd_ptr[DEPTH_LOG-1:0]),
    .rdata (w_rdata)
  );

  assign bus.is_full  = w_full;
  assign bus.is_empty = w_empty;
  assign bus.count    = r_wr_ptr - r_rd_ptr;
  assign bus.data_o   = w_empty ? '0 : w_rdata;
  assign bus.ovf      = r_ovf;
  assign bus.udf      = r_udf;

endmodule

`default_nettype wire
